led_pwm_controller: RTL
=======================

Name: led_pwm_controller

Overview:
- Wishbone slave that sits downstream of the SoC wishbone crossbar, in its own address window.
- Drives the board user LEDs, or any on/off channel group, with per-channel PWM brightness.
- The CPU programs a global enable, a polarity bit, a prescaler and one duty register per channel.
- Outputs are glitch-free because duty updates take effect only at PWM period boundaries.

Parameters:
CHANNEL_COUNT, 7, number of PWM output channels (1..32).
LEVEL_WIDTH, 8, width of the PWM counter and duty registers (2..16).
ADDR_WIDTH, 32, width of wb_adr.

Ports:
sys_clk  input  1  system clock; all logic is in this single domain.
sys_rst_n  input  1  asynchronous, active-low reset.
wb_cyc  input  1  wishbone cycle.
wb_stb  input  1  wishbone strobe.
wb_we  input  1  write enable.
wb_tag  input  4  cycle tag; accepted and ignored.
wb_sel  input  4  byte selects.
wb_adr  input  ADDR_WIDTH  byte address; only bits [7:2] are decoded.
wb_mosi  input  32  write data.
wb_miso  output  32  read data.
wb_ack  output  1  transfer acknowledge.
wb_err  output  1  error acknowledge.
pwm_out  output  CHANNEL_COUNT  PWM outputs; bit i is channel i.

Behaviour:
- Reset values (sys_rst_n low, asynchronous): wb_ack=0, wb_err=0, wb_miso=0, all registers 0, counters 0, pwm_out=0.
- Register map (word index = wb_adr[7:2]):
  - 0 CTRL: bit0 EN, bit1 INV. Other bits read 0.
  - 1 PRESCALE: bits[15:0].
  - 2+i DUTY[i] for i < CHANNEL_COUNT: bits[LEVEL_WIDTH-1:0].
- Bus handshake:
  - A request is wb_cyc & wb_stb & ~wb_ack & ~wb_err.
  - Exactly one of wb_ack or wb_err is asserted for one cycle, in the cycle after the request (latency 1).
  - No request is accepted in the response cycle, so peak rate is one transfer per 2 cycles.
  - If wb_cyc falls during the request cycle, the response is still issued and the master ignores it.
  - Index >= 2+CHANNEL_COUNT: wb_err=1, no register change, wb_miso=0.
- Writes: per-byte via wb_sel; bits above a register's width are discarded. wb_sel=0 completes with ack and no change.
- Reads: registered; wb_miso is valid in the ack cycle and is 0 in all other cycles.
- Prescaler:
  - pre_cnt counts 0..PRESCALE and wraps to 0.
  - tick = (pre_cnt==PRESCALE). PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE below the current pre_cnt forces pre_cnt to 0 in the next cycle, so no 65536-cycle stall.
- Period counter:
  - pwm_cnt is LEVEL_WIDTH bits, advances on tick, counts 0..2^W-2 and wraps to 0.
  - Period = (2^W-1)*(PRESCALE+1) cycles.
  - wrap = tick & (pwm_cnt==2^W-2).
- Shadow duty: duty_act[i] loads DUTY[i] on wrap, and also while EN=0. A new value therefore applies from the next period start.
- Output (registered, one cycle after counter state):
  - pwm_out[i] = EN ? ((pwm_cnt < duty_act[i]) ^ INV) : INV.
  - Duty 0 is always off; duty 2^W-1 is always on.
- EN 1->0: counters clear to 0 the next cycle and hold. Outputs go to the INV level one cycle after the CTRL ack.
- EN 0->1: the period starts at pwm_cnt=0 with the current DUTY values.
- Simultaneous DUTY write and wrap in the same cycle: the shadow loads the old DUTY value; the new value applies at the following wrap.
- Reset mid-transfer: the response is dropped and no ack is issued after reset release.

Optional Feature:
- Macro: LED_PWM_FADE_EN.
- Defined:
  - DUTY[i] is a target value. At each wrap, duty_act[i] steps by +/-1 toward DUTY[i] and stops when equal.
  - While EN=0, duty_act still loads DUTY directly.
  - CTRL bit2 FADE_BUSY (read-only) = 1 while any duty_act != DUTY.
- Not defined: duty_act loads DUTY directly at wrap, and CTRL bit2 reads 0.

Test Plan (CHANNEL_COUNT=7, LEVEL_WIDTH=8):
- Reset then read CTRL, PRESCALE, DUTY0..6 -> each returns 0 with a single-cycle ack one cycle after stb; pwm_out=0.
- Write PRESCALE=0, DUTY0=64, CTRL=1 -> pwm_out[0] high for 64 of every 255 cycles, period exactly 255 cycles, other channels low.
- DUTY1=255, DUTY2=0, CTRL=3 (INV) -> pwm_out[1] constantly 0, pwm_out[2] constantly 1.
- Read or write at byte address 0x24 (index 9) -> wb_err=1 for one cycle, wb_ack=0, no register change.
- Mid-period write DUTY0=200 while DUTY0=64 is active -> pulse width stays 64 until the next wrap, then 200; no glitch.
- (FADE) DUTY3 0->4, PRESCALE=0, EN=1 -> high time grows 1,2,3,4 over 4 periods; FADE_BUSY=1 until it reaches 4, then 0.

Source files
------------

// File: rtl/led_pwm_controller_if.sv
// Wishbone slave bundle for the LED PWM controller: one request/response
// channel with separate ack and err responses.
interface led_pwm_controller_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [3:0]            wb_tag;
    logic [3:0]            wb_sel;
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [31:0]           wb_mosi;
    logic [31:0]           wb_miso;
    logic                  wb_ack;
    logic                  wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_tag, wb_sel, wb_adr, wb_mosi,
        input  wb_miso, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_tag, wb_sel, wb_adr, wb_mosi,
        output wb_miso, wb_ack, wb_err
    );
endinterface

// File: rtl/led_pwm_controller.sv
// Wishbone-programmed multi-channel PWM with period-aligned duty shadowing.
// Define LED_PWM_FADE_EN to make duty registers fade targets (+/-1 per period).
module led_pwm_controller #(
    parameter int CHANNEL_COUNT = 7,
    parameter int LEVEL_WIDTH   = 8,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    led_pwm_controller_if.slave      bus,
    output logic [CHANNEL_COUNT-1:0] pwm_out
);

    localparam int NUM_REGS = 2 + CHANNEL_COUNT;
    localparam logic [LEVEL_WIDTH-1:0] LAST_CNT = LEVEL_WIDTH'((1 << LEVEL_WIDTH) - 2);

    logic [5:0]             idx;
    logic                   req;
    logic                   hit;
    logic                   wr_en;
    logic [15:0]            byte_mask;
    logic [31:0]            rd_data;

    logic                   en;
    logic                   inv;
    logic [15:0]            prescale;
    logic [LEVEL_WIDTH-1:0] duty     [CHANNEL_COUNT];
    logic [LEVEL_WIDTH-1:0] duty_act [CHANNEL_COUNT];

    logic [15:0]            pre_cnt;
    logic [LEVEL_WIDTH-1:0] pwm_cnt;
    logic                   tick;
    logic                   wrap;
    logic                   fade_busy;

    assign idx       = bus.wb_adr[7:2];
    assign req       = bus.wb_cyc & bus.wb_stb & ~bus.wb_ack & ~bus.wb_err;
    assign hit       = (idx < 6'(NUM_REGS));
    assign wr_en     = req & hit & bus.wb_we;
    assign byte_mask = {{8{bus.wb_sel[1]}}, {8{bus.wb_sel[0]}}};
    assign tick      = (pre_cnt == prescale);
    assign wrap      = en & tick & (pwm_cnt == LAST_CNT);

    wire unused = &{1'b0, bus.wb_tag, bus.wb_adr[ADDR_WIDTH-1:8], bus.wb_adr[1:0],
                    bus.wb_mosi, bus.wb_sel, byte_mask};

    // A response blocks the next request, so transfers alternate with response cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.wb_ack  <= 1'b0;
            bus.wb_err  <= 1'b0;
            bus.wb_miso <= '0;
        end else begin
            bus.wb_ack  <= req & hit;
            bus.wb_err  <= req & ~hit;
            bus.wb_miso <= (req & hit & ~bus.wb_we) ? rd_data : '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en       <= 1'b0;
            inv      <= 1'b0;
            prescale <= '0;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                duty[i] <= '0;
            end
        end else if (wr_en) begin
            if (idx == 6'd0 && bus.wb_sel[0]) begin
                en  <= bus.wb_mosi[0];
                inv <= bus.wb_mosi[1];
            end
            if (idx == 6'd1) begin
                prescale <= (prescale & ~byte_mask) | (bus.wb_mosi[15:0] & byte_mask);
            end
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (idx == 6'(i + 2)) begin
                    duty[i] <= (duty[i] & ~byte_mask[LEVEL_WIDTH-1:0])
                             | (bus.wb_mosi[LEVEL_WIDTH-1:0] & byte_mask[LEVEL_WIDTH-1:0]);
                end
            end
        end
    end

    // pre_cnt above a freshly lowered PRESCALE restarts at 0 instead of wrapping at 2^16.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (!en) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= (pre_cnt >= prescale) ? 16'd0 : pre_cnt + 16'd1;
            if (tick) begin
                pwm_cnt <= (pwm_cnt == LAST_CNT) ? '0 : pwm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                duty_act[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (!en) begin
                    duty_act[i] <= duty[i];
                end else if (wrap) begin
`ifdef LED_PWM_FADE_EN
                    if (duty_act[i] < duty[i]) begin
                        duty_act[i] <= duty_act[i] + 1'b1;
                    end else if (duty_act[i] > duty[i]) begin
                        duty_act[i] <= duty_act[i] - 1'b1;
                    end
`else
                    duty_act[i] <= duty[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                pwm_out[i] <= en ? ((pwm_cnt < duty_act[i]) ^ inv) : inv;
            end
        end
    end

    always_comb begin
        fade_busy = 1'b0;
`ifdef LED_PWM_FADE_EN
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (duty_act[i] != duty[i]) begin
                fade_busy = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        rd_data = '0;
        if (idx == 6'd0) begin
            rd_data[2:0] = {fade_busy, inv, en};
        end
        if (idx == 6'd1) begin
            rd_data[15:0] = prescale;
        end
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (idx == 6'(i + 2)) begin
                rd_data[LEVEL_WIDTH-1:0] = duty[i];
            end
        end
    end

endmodule
